// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register-memory responder:
// response codes, FSM state encodings, widths and the byte-strobe merge helper.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'b00,
        W_WAIT_DATA = 2'b01,
        W_WAIT_ADDR = 2'b10,
        W_RESP      = 2'b11
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Merge new data into an old word. Only the byte lanes whose strobe bit is set are replaced.
    function automatic logic [DATA_W-1:0] apply_strobe(
        input logic [DATA_W-1:0] i_old,
        input logic [DATA_W-1:0] i_new,
        input logic [STRB_W-1:0] i_strb
    );
        logic [DATA_W-1:0] res;
        for (int n = 0; n < STRB_W; n++) begin
            if (i_strb[n]) begin
                res[8*n +: 8] = i_new[8*n +: 8];
            end else begin
                res[8*n +: 8] = i_old[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// DEPTH x 32 storage with one strobed synchronous write port, one registered
// read port and a synchronous clear. A read on the same edge as a write to the
// same word returns the old contents.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic              i_re,
    input  logic              i_rzero,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage: the clear takes priority over any write on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= apply_strobe(r_mem[i_waddr], i_wdata, i_wstrb);
        end
    end

    // Read port: the word is captured on the accepted read and held until the next one.
    // A read flagged as out of range returns zero.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_rdata <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= i_rzero ? {DATA_W{1'b0}} : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite responder backed by a small word-addressed memory. The write and
// read channels each have an independent FSM. All handshake outputs are registered.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);

    w_state_e          r_wstate, w_wstate_nxt;
    r_state_e          r_rstate, w_rstate_nxt;
    logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic              w_aw_hs, w_w_hs, w_ar_hs;
    logic              w_wr_done, w_wr_in_range, w_we, w_rd_in_range;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [STRB_W-1:0] w_wr_strb;
    logic [DATA_W-1:0] w_rf_rdata;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid  & r_wready;
    assign w_ar_hs = s_axi_arvalid & r_arready;

    // Write FSM next state. Also selects the address, data and strobe of the completing write
    // from the live channel or the held copy.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_done    = 1'b0;
        w_wr_addr    = s_axi_awaddr;
        w_wr_data    = s_axi_wdata;
        w_wr_strb    = s_axi_wstrb;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_wr_done    = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_WAIT_DATA;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_WAIT_ADDR;
                end else begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_WAIT_DATA: begin
                w_wr_addr = r_aw_addr;
                if (w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_wr_done    = 1'b1;
                end else begin
                    w_wstate_nxt = W_WAIT_DATA;
                end
            end
            W_WAIT_ADDR: begin
                w_wr_data = r_wdata;
                w_wr_strb = r_wstrb;
                if (w_aw_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_wr_done    = 1'b1;
                end else begin
                    w_wstate_nxt = W_WAIT_ADDR;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_wstate_nxt = W_IDLE;
                end else begin
                    w_wstate_nxt = W_RESP;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    assign w_wr_in_range = (w_wr_addr[ADDR_WIDTH-1:2] < DEPTH_W);
    assign w_we          = w_wr_done & w_wr_in_range;

    // Write channel state and registered outputs. The readies and bvalid are decoded
    // from the next state, so they change on the same edge as the state.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_addr <= {ADDR_WIDTH{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_wstrb   <= {STRB_W{1'b0}};
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_WAIT_ADDR);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_WAIT_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_wr_done) begin
                r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_aw_hs) begin
                r_aw_addr <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_nxt = R_DATA;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rstate_nxt = R_DATA;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    assign w_rd_in_range = (s_axi_araddr[ADDR_WIDTH-1:2] < DEPTH_W);

    // Read channel state and registered outputs. The response code is captured on the
    // accepted read, together with the data captured in the regfile.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axi_lite_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .i_clk   (s_axi_aclk),
        .i_srst  (s_axi_areset),
        .i_we    (w_we),
        .i_waddr (w_wr_addr[IDX_W+1:2]),
        .i_wdata (w_wr_data),
        .i_wstrb (w_wr_strb),
        .i_re    (w_ar_hs),
        .i_rzero (~w_rd_in_range),
        .i_raddr (s_axi_araddr[IDX_W+1:2]),
        .o_rdata (w_rf_rdata)
    );

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = w_rf_rdata;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed self-checking bench for axi_lite_slave_mem. Inputs are driven and outputs
// are sampled 1ns after each rising edge. Expected values are hand-computed constants.
module tb_axi_lite_slave_mem;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32)) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write with AW and W presented together; bready assumed 1.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        check("wr_rdy_pre", {30'd0, awready, wready}, 32'd3);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, {30'd0, exp_resp});
        check("wr_rdy_in_resp", {30'd0, awready, wready}, 32'd0);
        tick();
        check("wr_bvalid_done", {31'd0, bvalid}, 32'd0);
    endtask

    // Single read; rready assumed 1.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp);
        check("rd_arready_pre", {31'd0, arready}, 32'd1);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        check("rd_rdata", rdata, exp_d);
        check("rd_rresp", {30'd0, rresp}, {30'd0, exp_resp});
        check("rd_arready_busy", {31'd0, arready}, 32'd0);
        tick();
        check("rd_rvalid_done", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; awaddr = 32'd0; wdata = 32'd0; araddr = 32'd0;
        awprot = 3'd0; arprot = 3'd0; wstrb = 4'd0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;

        // Reset held for 5 cycles while the valids toggle.
        for (int i = 0; i < 5; i++) begin
            awvalid = i[0]; wvalid = ~i[0]; arvalid = i[1];
            tick();
            check("rst_ctrl", {25'd0, awready, wready, arready, bvalid, rvalid, 2'b00},
                  32'd0);
            check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        areset = 1'b0;
        tick();
        check("post_rst_rdy", {29'd0, awready, wready, arready}, 32'd7);
        check("post_rst_resp_valid", {30'd0, bvalid, rvalid}, 32'd0);

        // Aligned write then readback.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read(32'h04, 32'hDEADBEEF, 2'b00);

        // Partial strobe over the existing word.
        do_write(32'h04, 32'h11223344, 4'b0101, 2'b00);
        do_read(32'h04, 32'hDE22BE44, 2'b00);

        // An all-zero strobe is an OKAY no-op. Address bits [1:0] are ignored.
        do_write(32'h07, 32'hFFFFFFFF, 4'h0, 2'b00);
        do_read(32'h06, 32'hDE22BE44, 2'b00);

        // Skewed: AW first, then W three cycles later.
        awaddr = 32'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("awfirst_wait_rdy", {30'd0, awready, wready}, 32'd1);
            check("awfirst_wait_b", {31'd0, bvalid}, 32'd0);
            tick();
        end
        check("awfirst_wait_rdy", {30'd0, awready, wready}, 32'd1);
        awaddr = 32'hFC; wdata = 32'h0000001F; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("awfirst_bvalid", {31'd0, bvalid}, 32'd1);
        check("awfirst_bresp", {30'd0, bresp}, 32'd0);
        tick();
        check("awfirst_bdone", {31'd0, bvalid}, 32'd0);

        // Skewed: W first, then AW three cycles later.
        wdata = 32'h0000001F; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0; wdata = 32'hAAAAAAAA;
        for (int i = 0; i < 2; i++) begin
            check("wfirst_wait_rdy", {30'd0, awready, wready}, 32'd2);
            check("wfirst_wait_b", {31'd0, bvalid}, 32'd0);
            tick();
        end
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
        check("wfirst_bresp", {30'd0, bresp}, 32'd0);
        tick();
        check("wfirst_bdone", {31'd0, bvalid}, 32'd0);
        do_read(32'h08, 32'h0000001F, 2'b00);
        do_read(32'h0C, 32'h0000001F, 2'b00);

        // Out of range: neighbouring words must be unaffected.
        do_write(32'h00, 32'hA5A50000, 4'hF, 2'b00);
        do_write(32'h7C, 32'h00005A5A, 4'hF, 2'b00);
        do_write(32'h80, 32'h12345678, 4'hF, 2'b10);
        do_read(32'h00, 32'hA5A50000, 2'b00);
        do_read(32'h7C, 32'h00005A5A, 2'b00);
        do_read(32'h80, 32'h00000000, 2'b10);

        // Same-edge collision: the read sees the pre-write value.
        awaddr = 32'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_bvalid", {31'd0, bvalid}, 32'd1);
        check("coll_rvalid", {31'd0, rvalid}, 32'd1);
        check("coll_rdata_old", rdata, 32'h0000001F);
        tick();
        do_read(32'h08, 32'hCAFEF00D, 2'b00);

        // B backpressure: response held, no new write accepted.
        bready = 1'b0;
        awaddr = 32'h10; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_bvalid", {31'd0, bvalid}, 32'd1);
            check("bp_bresp", {30'd0, bresp}, 32'd0);
            check("bp_rdy", {30'd0, awready, wready}, 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bp_bdone", {31'd0, bvalid}, 32'd0);
        check("bp_rdy_back", {30'd0, awready, wready}, 32'd3);
        do_read(32'h10, 32'h00000055, 2'b00);

        // Reset while a read response is pending.
        rready = 1'b0;
        araddr = 32'h04; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rst_mid_rvalid", {31'd0, rvalid}, 32'd1);
        check("rst_mid_rdata", rdata, 32'hDE22BE44);
        tick();
        check("rst_mid_hold_rvalid", {31'd0, rvalid}, 32'd1);
        check("rst_mid_hold_rdata", rdata, 32'hDE22BE44);
        areset = 1'b1;
        tick();
        check("rst_mid_rvalid_drop", {31'd0, rvalid}, 32'd0);
        check("rst_mid_rdata_clr", rdata, 32'd0);
        areset = 1'b0;
        rready = 1'b1;
        tick();
        for (int w = 0; w < 32; w++) begin
            do_read(w * 4, 32'd0, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
